seg7_scan_rx: RTL and testbench
===============================

# seg7_scan_rx

Receive side of the seven-segment display interface. Monitors a time-multiplexed segment/anode bus, like the one driven by the adder-to-display path, and waits for each digit's pattern to settle. It then decodes each pattern back to a 4-bit hex value and presents a complete frame (all digits) on a valid/ready output. It sits between the display driver outputs and any checker or loopback logic that needs the displayed numbers as data.

## Interface
- NUM_DIGITS, 2, digits per frame (one anode line each)
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (min 2)

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- seg  in  7  segment pattern {g,f,e,d,c,b,a}, 1 = lit
- an  in  NUM_DIGITS  digit select, one-hot, 1 = active
- frame_data  out  4*NUM_DIGITS  decoded digits, digit i at [4i+3:4i]
- frame_err  out  NUM_DIGITS  bit i set = digit i pattern not in decode table
- frame_valid  out  1  frame_data/frame_err valid
- frame_ready  in  1  consumer accepts frame when high with frame_valid
- frame_drop  out  1  one-cycle pulse: completed frame discarded (output busy)

## Operation
- Input stage: {seg,an} registered each cycle into smp. A stability counter compares each new sample with smp:
  - mismatch: counter clears to 0.
  - match: counter increments, saturating at STABLE_CYCLES-1.
- Capture FSM, states SETTLING and CAPTURED:
  - SETTLING -> CAPTURED when the counter reaches STABLE_CYCLES-1 and an is exactly one-hot. This writes the decoded digit and err bit into slot i (i = index of the set an bit) and sets mask[i].
  - In SETTLING, an all-zero or multi-hot an is never captured; the counter still runs.
  - CAPTURED -> SETTLING on any sample mismatch. A steady digit is captured once only.
- Decode table (seg hex -> value):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F
  - Any other pattern -> value 0, err 1.
- Recapturing a slot before the frame completes overwrites that slot.
- Frame completion: the cycle after mask becomes all ones, mask clears and the frame is offered to the output register.
  - Output register free (frame_valid=0, or frame_valid & frame_ready in the same cycle): frame loads, frame_valid=1.
  - Output register busy (frame_valid & !frame_ready): the new frame is discarded, frame_drop pulses, and the held frame is unchanged.
- Handshake: frame_data/frame_err stay stable while frame_valid & !frame_ready. Transfer occurs on a clock edge with both high; frame_valid falls next cycle unless a new frame loads on that same edge.
- Reset (any time, including mid-frame):
  - smp=0, counter=0, FSM=SETTLING, mask=0.
  - frame_data=0, frame_err=0, frame_valid=0, frame_drop=0.
  - Partial frames are lost.

## Timing
- Capture edge: the STABLE_CYCLES-th consecutive edge that samples identical {seg,an}.
- frame_valid rises 1 cycle after the capture edge of the last missing digit.
- Minimum digit dwell for capture: STABLE_CYCLES cycles. Glitches shorter than that are ignored.
- frame_drop is registered and coincides with the cycle the frame would have loaded.
- No combinational path from inputs to outputs.

## Structure
- Shared display package holds:
  - the 16 segment-pattern constants, {g..a} bit order
  - the capture FSM state enum
  - the digit width constant (4)
- Sub-module seg7_to_hex: combinational 7-bit pattern -> {err, value[3:0]} using the package constants. The transmit-side encoder uses the same constants.
- Top level: input stage, stability counter, capture FSM, mask/slot registers, output register.

## Test plan
- Reset: hold rst high with inputs active. Required: all outputs 0. Release rst, drive an=01 seg=06 for 4 cycles and an=10 seg=5B for 4 cycles. Required: frame_data=8'h21, frame_err=00, frame_valid=1 one cycle after the second capture.
- Glitch: an=01 seg=7F for 3 cycles, then seg=6F for 4 cycles; an=10 seg=3F for 4 cycles. Required: digit0=9 (7F never captured), frame_data=8'h09.
- Invalid pattern: an=01 seg=00 for 4 cycles, an=10 seg=71 for 4 cycles. Required: frame_data=8'hF0, frame_err=01.
- Backpressure: frame_ready=0 and two complete frames (12, then 34). Required: first frame held at 8'h12, frame_drop pulses once, 8'h34 never appears. Raise frame_ready: valid drops next cycle.
- Simultaneous: frame_ready=1 on the exact edge a new frame completes. Required: new frame loads, frame_valid stays 1, no drop.
- Mid-frame reset: capture digit0 only, pulse rst, then capture digit1 only. Required: no frame_valid until digit0 is recaptured.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment display definitions: segment patterns in {g,f,e,d,c,b,a}
// order (1 = lit), digit width and the receive-side capture state encoding.
package seg7_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic {
        SETTLING = 1'b0,
        CAPTURED = 1'b1
    } cap_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational segment-pattern decoder; unknown patterns give value 0 with err set.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0]         seg,
    output logic [DIGIT_W-1:0] value,
    output logic               err
);

    always_comb begin
        value = '0;
        err   = 1'b0;
        case (seg)
            SEG_0:   value = 4'h0;
            SEG_1:   value = 4'h1;
            SEG_2:   value = 4'h2;
            SEG_3:   value = 4'h3;
            SEG_4:   value = 4'h4;
            SEG_5:   value = 4'h5;
            SEG_6:   value = 4'h6;
            SEG_7:   value = 4'h7;
            SEG_8:   value = 4'h8;
            SEG_9:   value = 4'h9;
            SEG_A:   value = 4'hA;
            SEG_B:   value = 4'hB;
            SEG_C:   value = 4'hC;
            SEG_D:   value = 4'hD;
            SEG_E:   value = 4'hE;
            SEG_F:   value = 4'hF;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_rx.sv
// Receive side of the multiplexed display bus: waits for each digit to settle,
// decodes it into its slot and hands complete frames out on a valid/ready port.
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [6:0]                    seg,
    input  logic [NUM_DIGITS-1:0]         an,
    output logic [DIGIT_W*NUM_DIGITS-1:0] frame_data,
    output logic [NUM_DIGITS-1:0]         frame_err,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic                          frame_drop
);

    localparam int SMP_W = 7 + NUM_DIGITS;
    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SMP_W-1:0]              smp_q, smp_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    cap_state_e                    state_q, state_d;
    logic [NUM_DIGITS-1:0]         mask_q, mask_d;
    logic [DIGIT_W*NUM_DIGITS-1:0] slot_data_q, slot_data_d;
    logic [NUM_DIGITS-1:0]         slot_err_q, slot_err_d;
    logic [DIGIT_W*NUM_DIGITS-1:0] frame_data_q, frame_data_d;
    logic [NUM_DIGITS-1:0]         frame_err_q, frame_err_d;
    logic                          frame_valid_q, frame_valid_d;
    logic                          frame_drop_q, frame_drop_d;

    logic                  match;
    logic                  capture;
    logic                  frame_done;
    logic [NUM_DIGITS-1:0] smp_an;
    logic [6:0]            smp_seg;
    logic [IDX_W-1:0]      cap_idx;
    logic [DIGIT_W-1:0]    dec_value;
    logic                  dec_err;

    assign smp_an  = smp_q[NUM_DIGITS-1:0];
    assign smp_seg = smp_q[SMP_W-1 -: 7];
    assign match   = ({seg, an} == smp_q);

    seg7_to_hex u_dec (
        .seg   (smp_seg),
        .value (dec_value),
        .err   (dec_err)
    );

    always_comb begin
        smp_d = {seg, an};
        cnt_d = '0;
        if (match) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (smp_an[i]) cap_idx = IDX_W'(i);
        end
    end

    // Capture fires on the edge where the count reaches its top, so the digit
    // lands on the STABLE_CYCLES-th identical sample; on a match smp equals the input.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            SETTLING: begin
                if (match && cnt_d == CNT_MAX && $onehot(smp_an)) begin
                    capture = 1'b1;
                    state_d = CAPTURED;
                end
            end
            CAPTURED: begin
                if (!match) state_d = SETTLING;
            end
            default: state_d = SETTLING;
        endcase
    end

    assign frame_done = &mask_q;

    always_comb begin
        mask_d      = frame_done ? '0 : mask_q;
        slot_data_d = slot_data_q;
        slot_err_d  = slot_err_q;
        if (capture) begin
            mask_d[cap_idx]                         = 1'b1;
            slot_data_d[cap_idx*DIGIT_W +: DIGIT_W] = dec_value;
            slot_err_d[cap_idx]                     = dec_err;
        end
    end

    // A completed frame loads when the output register is empty or draining
    // this edge; otherwise it is dropped and the held frame is left alone.
    always_comb begin
        frame_data_d  = frame_data_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = frame_valid_q;
        frame_drop_d  = 1'b0;
        if (frame_valid_q && frame_ready) frame_valid_d = 1'b0;
        if (frame_done) begin
            if (!frame_valid_q || frame_ready) begin
                frame_data_d  = slot_data_q;
                frame_err_d   = slot_err_q;
                frame_valid_d = 1'b1;
            end else begin
                frame_drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q         <= '0;
            cnt_q         <= '0;
            state_q       <= SETTLING;
            mask_q        <= '0;
            slot_data_q   <= '0;
            slot_err_q    <= '0;
            frame_data_q  <= '0;
            frame_err_q   <= '0;
            frame_valid_q <= 1'b0;
            frame_drop_q  <= 1'b0;
        end else begin
            smp_q         <= smp_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            mask_q        <= mask_d;
            slot_data_q   <= slot_data_d;
            slot_err_q    <= slot_err_d;
            frame_data_q  <= frame_data_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= frame_valid_d;
            frame_drop_q  <= frame_drop_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_err   = frame_err_q;
    assign frame_valid = frame_valid_q;
    assign frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Directed bench for seg7_scan_rx: inputs change on falling edges, outputs are
// checked on falling edges against hand-computed values.
module tb_seg7_scan_rx;

    logic       clk;
    logic       rst;
    logic [6:0] seg;
    logic [1:0] an;
    logic [7:0] frame_data;
    logic [1:0] frame_err;
    logic       frame_valid;
    logic       frame_ready;
    logic       frame_drop;

    int n_checks;
    int n_errors;

    seg7_scan_rx #(
        .NUM_DIGITS    (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_drop  (frame_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; holds the pattern across n rising edges.
    task automatic hold(input logic [6:0] s, input logic [1:0] a, input int n);
        seg = s;
        an  = a;
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        seg         = 7'h7F;
        an          = 2'b01;
        frame_ready = 1'b0;

        // reset with active inputs
        step(3);
        check("rst_data", frame_data, 8'h00);
        check("rst_err", frame_err, 2'b00);
        check("rst_valid", frame_valid, 1'b0);
        check("rst_drop", frame_drop, 1'b0);
        rst = 1'b0;

        // basic frame 21
        hold(7'h06, 2'b01, 4);
        check("basic_d0_novalid", frame_valid, 1'b0);
        hold(7'h5B, 2'b10, 4);
        check("basic_capture_edge_novalid", frame_valid, 1'b0);
        step(1);
        check("basic_valid", frame_valid, 1'b1);
        check("basic_data", frame_data, 8'h21);
        check("basic_err", frame_err, 2'b00);
        check("basic_drop", frame_drop, 1'b0);
        frame_ready = 1'b1;
        step(1);
        check("basic_consumed", frame_valid, 1'b0);

        // glitch shorter than the dwell is ignored
        hold(7'h7F, 2'b01, 3);
        hold(7'h6F, 2'b01, 4);
        hold(7'h3F, 2'b10, 4);
        step(1);
        check("glitch_valid", frame_valid, 1'b1);
        check("glitch_data", frame_data, 8'h09);
        check("glitch_err", frame_err, 2'b00);
        step(1);
        check("glitch_consumed", frame_valid, 1'b0);

        // invalid pattern on digit 0
        hold(7'h00, 2'b01, 4);
        hold(7'h71, 2'b10, 4);
        step(1);
        check("inval_valid", frame_valid, 1'b1);
        check("inval_data", frame_data, 8'hF0);
        check("inval_err", frame_err, 2'b01);
        step(1);

        // backpressure: 12 held, 34 dropped
        frame_ready = 1'b0;
        hold(7'h5B, 2'b01, 4);
        hold(7'h06, 2'b10, 4);
        step(1);
        check("bp_first_valid", frame_valid, 1'b1);
        check("bp_first_data", frame_data, 8'h12);
        hold(7'h66, 2'b01, 4);
        hold(7'h4F, 2'b10, 4);
        check("bp_pre_drop", frame_drop, 1'b0);
        step(1);
        check("bp_drop_pulse", frame_drop, 1'b1);
        check("bp_held_data", frame_data, 8'h12);
        check("bp_held_valid", frame_valid, 1'b1);
        step(1);
        check("bp_drop_single", frame_drop, 1'b0);
        check("bp_still_held", frame_data, 8'h12);
        frame_ready = 1'b1;
        step(1);
        check("bp_released", frame_valid, 1'b0);
        check("bp_released_data", frame_data, 8'h12);

        // simultaneous transfer and load
        frame_ready = 1'b0;
        hold(7'h6D, 2'b01, 4);
        hold(7'h7D, 2'b10, 4);
        step(1);
        check("sim_first_data", frame_data, 8'h65);
        hold(7'h07, 2'b01, 4);
        hold(7'h7F, 2'b10, 4);
        check("sim_hold_data", frame_data, 8'h65);
        frame_ready = 1'b1;
        step(1);
        check("sim_valid", frame_valid, 1'b1);
        check("sim_data", frame_data, 8'h87);
        check("sim_no_drop", frame_drop, 1'b0);
        step(1);
        check("sim_consumed", frame_valid, 1'b0);

        // mid-frame reset loses digit 0; multi-hot anode never captures
        hold(7'h06, 2'b01, 4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        hold(7'h5B, 2'b10, 4);
        step(1);
        check("mrst_no_valid_a", frame_valid, 1'b0);
        step(3);
        check("mrst_no_valid_b", frame_valid, 1'b0);
        hold(7'h06, 2'b11, 6);
        check("mrst_multihot", frame_valid, 1'b0);
        hold(7'h06, 2'b01, 4);
        check("mrst_capture_edge", frame_valid, 1'b0);
        step(1);
        check("mrst_valid", frame_valid, 1'b1);
        check("mrst_data", frame_data, 8'h21);
        check("mrst_err", frame_err, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
